// File: rtl/padding_ctrl_pkg.sv
// Shared types and constants for the padding-row controller slice.
// Geometry defaults describe the 416-row source image with a 1-px zero border.
package padding_ctrl_pkg;

  localparam int DEF_IMG_H   = 416;
  localparam int DEF_CNT_W   = 9;
  localparam int PAD_ROWS    = 2;
  localparam int ROW_BITS    = DEF_IMG_H * 8;
  localparam int PADDED_BITS = (DEF_IMG_H + PAD_ROWS) * 8;

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_FETCH     = 6'b000010,
    S_LOAD      = 6'b000100,
    S_WAIT_INTR = 6'b001000,
    S_WIN       = 6'b010000,
    S_DONE      = 6'b100000
  } state_t;

endpackage

// File: rtl/padding_row_cnt.sv
// Padded-row counter r (0..IMG_H+1) with clear/increment and look-ahead flags
// that let the controller decide where the next row comes from.
module padding_row_cnt
  import padding_ctrl_pkg::*;
#(
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] r,
  output logic             lt_two,
  output logic             next_is_zero,
  output logic             is_last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r <= '0;
    else if (clr)
      r <= '0;
    else if (inc)
      r <= r + CNT_W'(1);
  end

  // next_is_zero: the row after r is the bottom zero border row
  assign lt_two       = (r < CNT_W'(2));
  assign next_is_zero = (r == CNT_W'(IMG_H));
  assign is_last      = (r == CNT_W'(IMG_H + 1));

endmodule

// File: rtl/padding_ctrl.sv
// Frame sequencer for the padding datapath: fetches source rows, pushes padded rows
// into the 3-row window and offers each full window to the conv stage.
module padding_ctrl
  import padding_ctrl_pkg::*;
#(
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             row_req,
  output logic [CNT_W-1:0] row_addr,
  input  logic             row_vld,
  output logic             pad_en,
  output logic [CNT_W-1:0] pad_count,
  output logic             pad_img_valid,
  output logic             pad_wait_en,
  input  logic             pad_intr,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  input  logic             win_ack
);

  state_t           state;
  logic [CNT_W-1:0] r;
  logic             lt_two;
  logic             next_is_zero;
  logic             is_last;
  logic             advance;
  logic             cnt_clr;
  logic             cnt_inc;

  // advance marks the "next row" step: after the first two pushes, or on a window ack
  assign advance = ((state == S_LOAD) && lt_two) || ((state == S_WIN) && win_ack);
  assign cnt_clr = abort || (state == S_DONE) || ((state == S_IDLE) && start);
  assign cnt_inc = advance && !is_last;

  padding_row_cnt #(
    .IMG_H(IMG_H),
    .CNT_W(CNT_W)
  ) u_row_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .r           (r),
    .lt_two      (lt_two),
    .next_is_zero(next_is_zero),
    .is_last     (is_last)
  );

  // Outputs are registered and set on entry to the state that owns them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_req       <= 1'b0;
      row_addr      <= '0;
      pad_en        <= 1'b0;
      pad_count     <= '0;
      pad_img_valid <= 1'b0;
      pad_wait_en   <= 1'b0;
      win_valid     <= 1'b0;
      win_row       <= '0;
    end else if (abort) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_req       <= 1'b0;
      row_addr      <= '0;
      pad_en        <= 1'b0;
      pad_count     <= '0;
      pad_img_valid <= 1'b0;
      pad_wait_en   <= 1'b0;
      win_valid     <= 1'b0;
      win_row       <= '0;
    end else begin
      pad_en        <= 1'b0;
      pad_img_valid <= 1'b0;
      done          <= 1'b0;
      if (advance) begin
        win_valid   <= 1'b0;
        pad_wait_en <= 1'b0;
        if (is_last) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else if (next_is_zero) begin
          state         <= S_LOAD;
          pad_en        <= 1'b1;
          pad_img_valid <= 1'b1;
          pad_count     <= r + CNT_W'(1);
        end else begin
          state    <= S_FETCH;
          row_req  <= 1'b1;
          row_addr <= r;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state         <= S_LOAD;
              busy          <= 1'b1;
              pad_en        <= 1'b1;
              pad_img_valid <= 1'b1;
              pad_count     <= '0;
            end
          end
          S_FETCH: begin
            if (row_vld) begin
              state         <= S_LOAD;
              row_req       <= 1'b0;
              pad_en        <= 1'b1;
              pad_img_valid <= 1'b1;
              pad_count     <= r;
            end
          end
          S_LOAD: state <= S_WAIT_INTR;
          S_WAIT_INTR: begin
            if (pad_intr) begin
              state       <= S_WIN;
              win_valid   <= 1'b1;
              pad_wait_en <= 1'b1;
              win_row     <= r - CNT_W'(2);
            end
          end
          S_WIN: begin
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
